// File: rtl/ssu_pkg.sv
// Shared superscalar issue types and constants.
// Instruction word type, NOP encoding and default buffer depth.
package ssu_pkg;
  typedef logic [31:0] ins_t;
  localparam ins_t NOP = 32'h0000_0013;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/ins_pair_buffer.sv
// Instruction pair buffer feeding the SSU Ins1/Ins2 inputs.
// Optional PAIR_BUF_STATS_EN adds dual_cnt/single_cnt counters.
module ins_pair_buffer
  import ssu_pkg::*;
#(
  parameter int          DEPTH    = DEF_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  ins_t        mem_rdata,
  output logic        mem_ready,
  output logic [31:0] fetch_pc,
  output ins_t        Ins1,
  output ins_t        Ins2,
  output logic        v1,
  output logic        v2,
  output logic [31:0] pc1,
  input  logic        adv,
  input  logic        dual,
  input  logic        flush,
  input  logic [31:0] flush_pc
`ifdef PAIR_BUF_STATS_EN
  ,
  output logic [31:0] dual_cnt,
  output logic [31:0] single_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ins_t          mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head1;
  logic [CW-1:0] count;
  logic [1:0]    take;
  logic          acc;

  assign mem_ready = count < FULL;
  assign v1 = count != '0;
  assign v2 = count >= CW'(2);
  assign head1 = head + PW'(1);
  assign Ins1 = v1 ? mem[head] : NOP;
  assign Ins2 = v2 ? mem[head1] : NOP;

  // Consume amount; dual degrades to single when only one word is held.
  always_comb begin
    take = 2'd0;
    if (dual && v2)
      take = 2'd2;
    else if ((adv || dual) && v1)
      take = 2'd1;
  end

  // A full buffer still takes a word when a slot frees this cycle.
  always_comb begin
    acc = 1'b0;
    if (mem_valid && (mem_ready || take != 2'd0))
      acc = 1'b1;
  end

  // Pointer, count and PC state; reset beats flush beats normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      pc1      <= RESET_PC;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= flush_pc;
      pc1      <= flush_pc;
    end else begin
      if (acc) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      head  <= head + PW'(take);
      pc1   <= pc1 + {28'd0, take, 2'b00};
      count <= count + CW'(acc) - CW'(take);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && !flush && acc)
      mem[tail] <= mem_rdata;
  end

`ifdef PAIR_BUF_STATS_EN
  // Issue statistics survive flush and wrap silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
    end else if (!flush) begin
      if (take == 2'd2)
        dual_cnt <= dual_cnt + 32'd1;
      if (take == 2'd1)
        single_cnt <= single_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_pair_buffer.sv
// Directed vector bench for ins_pair_buffer.
// Table of single-cycle vectors plus multi-cycle corner sequences.
module tb_ins_pair_buffer;
  import ssu_pkg::*;

  localparam logic [31:0] W0 = 32'h0094_0333;
  localparam logic [31:0] W1 = 32'h4099_0333;
  localparam logic [31:0] W2 = 32'h00a0_0413;
  localparam logic [31:0] W3 = 32'h0057_e3b3;
  localparam logic [31:0] W4 = 32'h1234_5678;
  localparam logic [31:0] W5 = 32'h0bad_f00d;
  localparam logic [31:0] NP = 32'h0000_0013;

  typedef struct packed {
    logic        rst;
    logic        mv;
    logic [31:0] rd;
    logic        adv;
    logic        dual;
    logic        fl;
    logic [31:0] fpc;
  } in_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] fpc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        v1;
    logic        v2;
    logic [31:0] pc1;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] fetch_pc;
  logic [31:0] Ins1;
  logic [31:0] Ins2;
  logic        v1;
  logic        v2;
  logic [31:0] pc1;
  logic        adv;
  logic        dual;
  logic        flush;
  logic [31:0] flush_pc;
`ifdef PAIR_BUF_STATS_EN
  logic [31:0] dual_cnt;
  logic [31:0] single_cnt;
`endif

  int total = 0;
  int passed = 0;

  ins_pair_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .fetch_pc  (fetch_pc),
    .Ins1      (Ins1),
    .Ins2      (Ins2),
    .v1        (v1),
    .v2        (v2),
    .pc1       (pc1),
    .adv       (adv),
    .dual      (dual),
    .flush     (flush),
    .flush_pc  (flush_pc)
`ifdef PAIR_BUF_STATS_EN
    ,
    .dual_cnt  (dual_cnt),
    .single_cnt(single_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input in_t i);
    reset     = i.rst;
    mem_valid = i.mv;
    mem_rdata = i.rd;
    adv       = i.adv;
    dual      = i.dual;
    flush     = i.fl;
    flush_pc  = i.fpc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input out_t e, input string name);
    out_t a;
    a = '{mem_ready, fetch_pc, Ins1, Ins2, v1, v2, pc1};
    total++;
    if (a === e) passed++;
    else
      $display("FAIL %s: got rdy=%b fpc=%h i1=%h i2=%h v=%b%b pc1=%h want rdy=%b fpc=%h i1=%h i2=%h v=%b%b pc1=%h",
        name, a.rdy, a.fpc, a.i1, a.i2, a.v1, a.v2, a.pc1,
        e.rdy, e.fpc, e.i1, e.i2, e.v1, e.v2, e.pc1);
  endtask

  task automatic step(input in_t i, input out_t e, input string name);
    drive(i);
    check(e, name);
    @(negedge clk);
  endtask

  task automatic chk32(input logic [31:0] a, input logic [31:0] e, input string name);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", name, a, e);
  endtask

  vec_t vec [15];

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_rdata = '0;
    adv = 1'b0;
    dual = 1'b0;
    flush = 1'b0;
    flush_pc = '0;

    //           rst mv rd  adv dual fl fpc        rdy fpc  i1 i2 v1 v2 pc1
    vec[0]  = '{'{1,0,0,0,0,0,0},   '{1,32'h00,NP,NP,0,0,32'h00}};
    vec[1]  = '{'{0,1,W0,0,0,0,0},  '{1,32'h04,W0,NP,1,0,32'h00}};
    vec[2]  = '{'{0,1,W1,0,0,0,0},  '{1,32'h08,W0,W1,1,1,32'h00}};
    vec[3]  = '{'{0,1,W2,0,0,0,0},  '{1,32'h0c,W0,W1,1,1,32'h00}};
    vec[4]  = '{'{0,1,W3,0,0,0,0},  '{0,32'h10,W0,W1,1,1,32'h00}};
    vec[5]  = '{'{0,1,W4,0,0,0,0},  '{0,32'h10,W0,W1,1,1,32'h00}};
    vec[6]  = '{'{0,0,0,0,1,0,0},   '{1,32'h10,W2,W3,1,1,32'h08}};
    vec[7]  = '{'{0,1,W4,1,0,0,0},  '{1,32'h14,W3,W4,1,1,32'h0c}};
    vec[8]  = '{'{0,0,0,1,0,0,0},   '{1,32'h14,W4,NP,1,0,32'h10}};
    vec[9]  = '{'{0,0,0,0,1,0,0},   '{1,32'h14,NP,NP,0,0,32'h14}};
    vec[10] = '{'{0,0,0,1,1,0,0},   '{1,32'h14,NP,NP,0,0,32'h14}};
    vec[11] = '{'{0,1,W5,0,1,1,32'h100},
                '{1,32'h100,NP,NP,0,0,32'h100}};
    vec[12] = '{'{0,1,W5,0,0,0,0},  '{1,32'h104,W5,NP,1,0,32'h100}};
    vec[13] = '{'{0,1,W0,1,0,0,0},  '{1,32'h108,W0,NP,1,0,32'h104}};
    vec[14] = '{'{1,1,W1,0,1,0,0},  '{1,32'h00,NP,NP,0,0,32'h00}};

    @(negedge clk);
    for (int k = 0; k < 15; k++)
      step(vec[k].i, vec[k].e, $sformatf("vec%0d", k));

    // Full buffer: accept with adv wraps tail, new word reaches Ins2.
    step('{1,0,0,0,0,0,0},  '{1,32'h00,NP,NP,0,0,32'h00}, "wrap_rst");
    drive('{0,1,W0,0,0,0,0});
    drive('{0,1,W1,0,0,0,0});
    drive('{0,1,W2,0,0,0,0});
    drive('{0,1,W3,0,0,0,0});
    check('{0,32'h10,W0,W1,1,1,32'h00}, "wrap_full");
    @(negedge clk);
    step('{0,1,W4,1,0,0,0}, '{0,32'h14,W1,W2,1,1,32'h04}, "wrap_acc_adv");
    step('{0,0,0,1,0,0,0},  '{1,32'h14,W2,W3,1,1,32'h08}, "wrap_adv1");
    step('{0,0,0,1,0,0,0},  '{1,32'h14,W3,W4,1,1,32'h0c}, "wrap_adv2");

`ifdef PAIR_BUF_STATS_EN
    drive('{1,0,0,0,0,0,0});
    drive('{0,1,W0,0,0,0,0});
    drive('{0,1,W1,0,0,0,0});
    drive('{0,1,W2,0,0,0,0});
    drive('{0,1,W3,0,0,0,0});
    drive('{0,1,W4,0,1,0,0});
    drive('{0,1,W5,0,1,0,0});
    drive('{0,1,W0,0,1,0,0});
    drive('{0,1,W1,1,0,0,0});
    drive('{0,0,0,1,0,0,0});
    drive('{0,0,0,1,1,1,32'h200});
    chk32(dual_cnt, 32'd3, "dual_cnt");
    chk32(single_cnt, 32'd2, "single_cnt");
    drive('{1,0,0,0,0,0,0});
    chk32(dual_cnt, 32'd0, "dual_cnt_rst");
    chk32(single_cnt, 32'd0, "single_cnt_rst");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ins_pair_buffer.md
INS_PAIR_BUFFER -- requirements
Module: ins_pair_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving buffer capacity in instruction words (power of 2, >= 4).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port mem_valid, input, 1 bit: instruction memory presents a word.
REQ-006 The block SHALL have port mem_rdata, input, 32 bits: instruction word at fetch_pc.
REQ-007 The block SHALL have port mem_ready, output, 1 bit: the buffer can accept a word this cycle.
REQ-008 The block SHALL have port fetch_pc, output, 32 bits: address of the next word to fetch.
REQ-009 The block SHALL have port Ins1, output, 32 bits: oldest buffered word, to the SSU Ins1 input.
REQ-010 The block SHALL have port Ins2, output, 32 bits: second-oldest buffered word, to the SSU Ins2 input.
REQ-011 The block SHALL have port v1, output, 1 bit: Ins1 holds a valid word.
REQ-012 The block SHALL have port v2, output, 1 bit: Ins2 holds a valid word.
REQ-013 The block SHALL have port pc1, output, 32 bits: PC of Ins1.
REQ-014 The block SHALL have port adv, input, 1 bit: issue stage consumes Ins1.
REQ-015 The block SHALL have port dual, input, 1 bit: issue stage consumes Ins1 and Ins2 (the SSU dual-issue decision).
REQ-016 The block SHALL have port flush, input, 1 bit: discard all buffered words and redirect.
REQ-017 The block SHALL have port flush_pc, input, 32 bits: redirect target, word-aligned.

Function
REQ-018 The buffer SHALL be a circular FIFO with head and tail pointers of width log2(DEPTH), plus an occupancy count of 0..DEPTH.
REQ-019 mem_ready SHALL be driven from registered state only, as (count < DEPTH), with no combinational path from adv, dual or flush.
REQ-020 A word SHALL be accepted when mem_valid and mem_ready are both high; it is written at tail, tail increments with wrap, and fetch_pc increments by 4.
REQ-021 v1 SHALL equal (count >= 1), and v2 SHALL equal (count >= 2).
REQ-022 Ins1 and Ins2 SHALL output the head and head+1 (wrapped) entries, or 32'h0000_0013 (NOP) when the corresponding valid bit is low.
REQ-023 The take amount SHALL be 2 if dual and v2; otherwise 1 if (adv or dual) and v1; otherwise 0.
REQ-024 A dual request with v2 low SHALL degrade to a single consume, and adv or dual with v1 low SHALL be ignored.
REQ-025 On each cycle, head SHALL advance by take with wrap, pc1 SHALL advance by 4*take, and count SHALL update as count + accept - take.
REQ-026 Accept and take in the same cycle SHALL both take effect, including when count = DEPTH with take >= 1; mem_ready remains low that cycle.
REQ-027 The outputs SHALL present zero-cycle latency from state: a word accepted in cycle N is visible on Ins1/Ins2 in cycle N+1.
REQ-028 When flush is high, the next state SHALL be count = 0, head = tail = 0, and fetch_pc = pc1 = flush_pc; accept and take in that cycle are discarded.
REQ-029 Pointer and PC arithmetic SHALL wrap modulo its width without error indication.

Reset
REQ-030 On reset high at a clock edge: count = 0, head = tail = 0, fetch_pc = pc1 = RESET_PC, v1 = v2 = 0, Ins1 = Ins2 = NOP, and mem_ready = 1 on the following cycle.
REQ-031 Reset SHALL take priority over flush, accept and take; buffered contents are abandoned mid-operation.
REQ-032 Storage array contents SHALL NOT require reset.

Configuration
REQ-033 When macro PAIR_BUF_STATS_EN is defined, the block SHALL add output ports dual_cnt (32 bits) and single_cnt (32 bits), counting cycles with take = 2 and take = 1 respectively; both clear on reset, do not clear on flush, and wrap on overflow.
REQ-034 When PAIR_BUF_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 Shared package ssu_pkg SHALL hold the instruction-word typedef, the NOP constant 32'h0000_0013, and the default DEPTH constant.
REQ-036 No sub-module is required; the storage array, pointers and counters SHALL reside in ins_pair_buffer.

Verification
REQ-037 Reset, then 4 words 0x00940333, 0x40990333, 0x00a00413, 0x0057e3b3 accepted with no consume -> count = 4, mem_ready = 0, fetch_pc = 0x10, Ins1 = 0x00940333, Ins2 = 0x40990333, v1 = v2 = 1.
REQ-038 From the full state, dual = 1 for one cycle -> pc1 = 0x08, Ins1 = 0x00a00413, Ins2 = 0x0057e3b3, count = 2, mem_ready = 1.
REQ-039 With count = 1, dual = 1 -> single consume, pc1 + 4, v1 = 0, Ins1 = Ins2 = NOP.
REQ-040 With count = 4, accept and adv in the same cycle -> count stays 4, tail wraps to 0, and the new word appears at Ins2 after 2 further adv cycles.
REQ-041 flush = 1, flush_pc = 0x100, with mem_valid and dual also high -> next cycle count = 0, fetch_pc = pc1 = 0x100, v1 = 0, and no word accepted.
REQ-042 With PAIR_BUF_STATS_EN defined, 3 dual and 2 single consumes -> dual_cnt = 3 and single_cnt = 2, and a subsequent reset clears both to 0.
